// File: rtl/unibus_pkg.sv
// Shared types and constants for the Unibus bus-ownership arbiter.
package unibus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StGrant,
    StMaster
  } arb_state_e;

  typedef enum logic [1:0] {
    GntNone,
    GntNpr,
    GntBr
  } gnt_type_e;

  // Bus priority level of bus_br[0]
  localparam int unsigned BrBaseLevel = 4;

  // Index width for n entries, never zero
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// Combinational fixed-priority encoder; MsbFirst selects whether the highest
// or the lowest set bit wins.
module arb_prio_enc
  import unibus_pkg::*;
#(
  parameter int unsigned Width    = 4,
  parameter bit          MsbFirst = 1'b0,
  localparam int unsigned IdxW    = idx_width(Width)
) (
  input  logic [Width-1:0] req_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    if (MsbFirst) begin
      for (int unsigned i = 0; i < Width; i++) begin
        if (req_i[i]) idx_o = IdxW'(i);
      end
    end else begin
      for (int i = int'(Width) - 1; i >= 0; i--) begin
        if (req_i[i]) idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/unibus_arbiter.sv
// Parametrised Unibus BR/NPR bus-ownership arbiter.
// Define UNIBUS_SACK_TIMEOUT_EN to build the no-SACK timeout and nosack pulse.
module unibus_arbiter
  import unibus_pkg::*;
#(
  parameter int unsigned NBR      = 4,
  parameter int unsigned NNPR     = 1,
  parameter int unsigned SYNC_DLY = 4,
  parameter int unsigned SACK_TMO = 500
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBR-1:0]  bus_br,
  input  logic [NNPR-1:0] bus_npr,
  input  logic            bus_sack,
  input  logic            bus_bbsy,
  input  logic            bus_init,
  input  logic [2:0]      ps_pl,
  input  logic            npr_ok,
  input  logic            br_ok,
  output logic [NBR-1:0]  bus_bg,
  output logic [NNPR-1:0] bus_npg,
  output logic            arb_busy,
  output logic            proc_release,
  output logic            nosack
);

  localparam int unsigned BrIdxW  = idx_width(NBR);
  localparam int unsigned NprIdxW = idx_width(NNPR);
  localparam int unsigned CntW    = idx_width(SYNC_DLY);

  arb_state_e      state_q, state_d;
  gnt_type_e       gtype_q, gtype_d;
  logic [CntW-1:0] settle_cnt_q, settle_cnt_d;
  logic [NBR-1:0]  bg_q, bg_d;
  logic [NNPR-1:0] npg_q, npg_d;
  // Bus request pins are asynchronous to clk; register them before use
  logic [NBR-1:0]  br_sync_q, br_sync_d;
  logic [NNPR-1:0] npr_sync_q, npr_sync_d;

  logic [NBR-1:0]     br_elig;
  logic [NNPR-1:0]    npr_elig;
  logic               br_valid, npr_valid;
  logic [BrIdxW-1:0]  br_idx;
  logic [NprIdxW-1:0] npr_idx;

  always_comb begin
    npr_elig = bus_npr_gate(npr_sync_q, npr_ok);
    for (int unsigned i = 0; i < NBR; i++) begin
      br_elig[i] = br_sync_q[i] && br_ok && ((BrBaseLevel + i) > {29'b0, ps_pl});
    end
  end

  function automatic logic [NNPR-1:0] bus_npr_gate(input logic [NNPR-1:0] req,
                                                    input logic ok);
    return ok ? req : '0;
  endfunction

  arb_prio_enc #(
    .Width    (NNPR),
    .MsbFirst (1'b0)
  ) u_npr_enc (
    .req_i   (npr_elig),
    .valid_o (npr_valid),
    .idx_o   (npr_idx)
  );

  arb_prio_enc #(
    .Width    (NBR),
    .MsbFirst (1'b1)
  ) u_br_enc (
    .req_i   (br_elig),
    .valid_o (br_valid),
    .idx_o   (br_idx)
  );

`ifdef UNIBUS_SACK_TIMEOUT_EN
  localparam int unsigned TmoW = idx_width(SACK_TMO);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            nosack_q, nosack_d;
`endif

  always_comb begin
    state_d      = state_q;
    gtype_d      = gtype_q;
    settle_cnt_d = settle_cnt_q;
    bg_d         = bg_q;
    npg_d        = npg_q;
    br_sync_d    = bus_br;
    npr_sync_d   = bus_npr;
`ifdef UNIBUS_SACK_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    nosack_d     = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (npr_valid || br_valid) begin
          state_d      = StSettle;
          settle_cnt_d = CntW'(SYNC_DLY - 1);
        end
      end
      StSettle: begin
        if (settle_cnt_q != '0) begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end else if (npr_valid) begin
          state_d = StGrant;
          gtype_d = GntNpr;
          npg_d   = NNPR'(1) << npr_idx;
          bg_d    = '0;
`ifdef UNIBUS_SACK_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else if (br_valid) begin
          state_d = StGrant;
          gtype_d = GntBr;
          bg_d    = NBR'(1) << br_idx;
          npg_d   = '0;
`ifdef UNIBUS_SACK_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        // SACK takes precedence over a timeout falling on the same edge
        if (bus_sack) begin
          state_d = StMaster;
          gtype_d = GntNone;
          bg_d    = '0;
          npg_d   = '0;
        end
`ifdef UNIBUS_SACK_TIMEOUT_EN
        else if (tmo_cnt_q == TmoW'(SACK_TMO - 1)) begin
          state_d  = StIdle;
          gtype_d  = GntNone;
          bg_d     = '0;
          npg_d    = '0;
          nosack_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      StMaster: begin
        if (!bus_sack && !bus_bbsy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus_init) begin
      state_d      = StIdle;
      gtype_d      = GntNone;
      settle_cnt_d = '0;
      bg_d         = '0;
      npg_d        = '0;
      br_sync_d    = '0;
      npr_sync_d   = '0;
`ifdef UNIBUS_SACK_TIMEOUT_EN
      tmo_cnt_d    = '0;
      nosack_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      gtype_q      <= GntNone;
      settle_cnt_q <= '0;
      bg_q         <= '0;
      npg_q        <= '0;
      br_sync_q    <= '0;
      npr_sync_q   <= '0;
    end else begin
      state_q      <= state_d;
      gtype_q      <= gtype_d;
      settle_cnt_q <= settle_cnt_d;
      bg_q         <= bg_d;
      npg_q        <= npg_d;
      br_sync_q    <= br_sync_d;
      npr_sync_q   <= npr_sync_d;
    end
  end

`ifdef UNIBUS_SACK_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      nosack_q  <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      nosack_q  <= nosack_d;
    end
  end
  assign nosack = nosack_q;
`else
  assign nosack = 1'b0;
`endif

  always_comb begin
    bus_bg       = ((state_q == StGrant) && (gtype_q == GntBr)) ? bg_q : '0;
    bus_npg      = ((state_q == StGrant) && (gtype_q == GntNpr)) ? npg_q : '0;
    arb_busy     = (state_q != StIdle);
    proc_release = (state_q == StMaster);
  end

endmodule
